instr_seq_checker: RTL and testbench

- Synthesizable, parametrised successor to the directed processor bench.
- Holds a programmable table of {instruction, check kind, expected value} entries and issues them to the processor's instruction input, one per fixed-length slot.
- Samples processor result or pc at a fixed cycle within each slot and tallies pass/fail.
- Sits beside the processor core; used in simulation and in FPGA self-test builds.

---
 rtl/instr_seq_pkg.sv | 31 +++
 rtl/seq_table_ram.sv | 28 ++
 rtl/instr_seq_checker.sv | 227 ++++++++++++++++++++++
 tb/tb_instr_seq_checker.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types for the instruction-sequence checker.
// No logic, no latency.
// No flow control.
package instr_seq_pkg;

    localparam int          PKG_XLEN = 64;
    localparam int          PKG_ILEN = 32;
    localparam logic [31:0] ISA_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_RESULT = 2'b01,
        KIND_PC     = 2'b10,
        KIND_RSVD   = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // One table entry at the default widths; the RAM stores the same fields
    // flattened so that XLEN/ILEN stay parameters of the checker.
    typedef struct packed {
        logic [PKG_ILEN-1:0] instr;
        kind_e               kind;
        logic [PKG_XLEN-1:0] exp_val;
    } entry_t;

endpackage

// File: rtl/seq_table_ram.sv
// Entry table: DEPTH x W storage.
// Synchronous write, combinational read.
// No flow control; the writer gates its own strobe.
module seq_table_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 98,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdat,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdat
);

    logic [W-1:0] mem_q [DEPTH];

    // Table contents survive reset, so the storage has no reset term.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdat;
        end
    end

    assign rdat = mem_q[raddr];

endmodule

// File: rtl/instr_seq_checker.sv
// Issues a programmed instruction table to a core and tallies result/pc checks.
// Instruction appears one cycle after start; each entry is held HOLD_CYCLES cycles.
// No backpressure: the core is assumed to consume one instruction per slot.
module instr_seq_checker
    import instr_seq_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              ILEN        = 32,
    parameter int              DEPTH       = 64,
    parameter int              HOLD_CYCLES = 2,
    parameter int              CHECK_AT    = 1,
    parameter logic [ILEN-1:0] NOP_INSTR   = ILEN'(ISA_NOP),
    parameter int              AW          = $clog2(DEPTH),
    parameter int              CW          = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [ILEN-1:0] prog_instr,
    input  logic [1:0]      prog_kind,
    input  logic [XLEN-1:0] prog_expect,
    input  logic [CW-1:0]   num_entries,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] result_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [ILEN-1:0] instruction,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   pass_cnt,
    output logic [CW-1:0]   fail_cnt,
    output logic [AW-1:0]   first_fail_idx,
    output logic            any_fail
);

    localparam int            HW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int            EW       = ILEN + 2 + XLEN;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [HW-1:0] C_CHECK  = HW'(CHECK_AT);
    localparam logic [HW-1:0] C_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0] IDX_NONE = '1;

    generate
        if (HOLD_CYCLES < 1 || CHECK_AT < 0 || CHECK_AT >= HOLD_CYCLES || DEPTH < 2) begin : g_bad_params
            $fatal(1, "instr_seq_checker: need HOLD_CYCLES>=1, 0<=CHECK_AT<HOLD_CYCLES, DEPTH>=2");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [HW-1:0]   c_q, c_d;
    logic [CW-1:0]   n_q, n_d;
    logic [ILEN-1:0] instr_q, instr_d;
    kind_e           kind_q, kind_d;
    logic [XLEN-1:0] exp_q, exp_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   pass_q, pass_d;
    logic [CW-1:0]   fail_q, fail_d;
    logic [AW-1:0]   ffi_q, ffi_d;
    logic            anyf_q, anyf_d;

    logic            tbl_we;
    logic [AW-1:0]   rd_addr;
    logic [EW-1:0]   wr_dat;
    logic [EW-1:0]   rd_dat;
    logic [EW-1:0]   ent;
    logic [ILEN-1:0] ent_instr;
    kind_e           ent_kind;
    logic [XLEN-1:0] ent_exp;
    logic [CW-1:0]   n_eff;
    logic [XLEN-1:0] sample;
    logic            chk_en;

    // The table is writable only while no run is in flight.
    assign tbl_we  = prog_we && (state_q != ST_RUN);
    assign wr_dat  = {prog_instr, prog_kind, prog_expect};
    // Outside a run the next entry to issue is always entry 0.
    assign rd_addr = (state_q == ST_RUN) ? idx_q + 1'b1 : '0;

    seq_table_ram #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (prog_addr),
        .wdat  (wr_dat),
        .raddr (rd_addr),
        .rdat  (rd_dat)
    );

    // Forward a same-cycle write so a start alongside prog_we sees the new entry.
    assign ent       = (tbl_we && (prog_addr == rd_addr)) ? wr_dat : rd_dat;
    assign ent_instr = ent[EW-1 -: ILEN];
    assign ent_kind  = kind_e'(ent[XLEN +: 2]);
    assign ent_exp   = ent[XLEN-1:0];

    assign n_eff  = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
    assign sample = (kind_q == KIND_PC) ? pc_i : result_i;
    assign chk_en = (kind_q == KIND_RESULT) || (kind_q == KIND_PC);

    // Next-state logic: abort wins over everything, start is only honoured when idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        n_d     = n_q;
        instr_d = instr_q;
        kind_d  = kind_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ffi_d   = ffi_q;
        anyf_d  = anyf_q;

        if (abort) begin
            state_d = ST_IDLE;
            instr_d = NOP_INSTR;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pass_d = '0;
                        fail_d = '0;
                        anyf_d = 1'b0;
                        ffi_d  = IDX_NONE;
                        if (num_entries == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            n_d     = n_eff;
                            idx_d   = '0;
                            c_d     = '0;
                            instr_d = ent_instr;
                            kind_d  = ent_kind;
                            exp_d   = ent_exp;
                            busy_d  = 1'b1;
                            done_d  = 1'b0;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if ((c_q == C_CHECK) && chk_en) begin
                        if (sample == exp_q) begin
                            pass_d = pass_q + 1'b1;
                        end else begin
                            fail_d = fail_q + 1'b1;
                            anyf_d = 1'b1;
                            if (!anyf_q) begin
                                ffi_d = idx_q;
                            end
                        end
                    end
                    if (c_q == C_LAST) begin
                        if ((CW'(idx_q) + CW'(1)) < n_q) begin
                            idx_d   = idx_q + 1'b1;
                            c_d     = '0;
                            instr_d = ent_instr;
                            kind_d  = ent_kind;
                            exp_d   = ent_exp;
                        end else begin
                            instr_d = NOP_INSTR;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Single state/output register bank; all outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            c_q     <= '0;
            n_q     <= '0;
            instr_q <= NOP_INSTR;
            kind_q  <= KIND_NONE;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            ffi_q   <= IDX_NONE;
            anyf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            n_q     <= n_d;
            instr_q <= instr_d;
            kind_q  <= kind_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ffi_q   <= ffi_d;
            anyf_q  <= anyf_d;
        end
    end

    assign instruction    = instr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign first_fail_idx = ffi_q;
    assign any_fail       = anyf_q;

endmodule

// File: tb/tb_instr_seq_checker.sv
// Self-checking bench for instr_seq_checker: directed vectors, hand sequences, random runs.
// Runs against a responder that maps each issued instruction to a result/pc value.
// Expected counts come from a per-entry model over the bench's copy of the table.
module tb_instr_seq_checker;
    import instr_seq_pkg::*;

    localparam int          XLEN   = 64;
    localparam int          ILEN   = 32;
    localparam int          DEPTH  = 64;
    localparam int          HOLD   = 2;
    localparam int          CHK_AT = 1;
    localparam int          AW     = 6;
    localparam int          CW     = 7;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          RM_MAX = 512;

    logic            clk = 1'b0;
    logic            reset;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [ILEN-1:0] prog_instr;
    logic [1:0]      prog_kind;
    logic [XLEN-1:0] prog_expect;
    logic [CW-1:0]   num_entries;
    logic            start;
    logic            abort;
    logic [XLEN-1:0] result_i;
    logic [XLEN-1:0] pc_i;
    logic [ILEN-1:0] instruction;
    logic            busy;
    logic            done;
    logic [CW-1:0]   pass_cnt;
    logic [CW-1:0]   fail_cnt;
    logic [AW-1:0]   first_fail_idx;
    logic            any_fail;

    int n_chk  = 0;
    int n_fail = 0;

    entry_t      tbl [DEPTH];
    logic [31:0] rm_instr [RM_MAX];
    logic [63:0] rm_res [RM_MAX];
    logic [63:0] rm_pc [RM_MAX];
    int          rm_n = 0;

    typedef struct {
        entry_t      e;
        logic [63:0] res;
        logic [63:0] pc;
        int          exp_p;
        int          exp_f;
    } vec_t;
    vec_t vecs [$];

    always #5 clk = ~clk;

    instr_seq_checker #(
        .XLEN        (XLEN),
        .ILEN        (ILEN),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .CHECK_AT    (CHK_AT),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_instr     (prog_instr),
        .prog_kind      (prog_kind),
        .prog_expect    (prog_expect),
        .num_entries    (num_entries),
        .start          (start),
        .abort          (abort),
        .result_i       (result_i),
        .pc_i           (pc_i),
        .instruction    (instruction),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .any_fail       (any_fail)
    );

    function automatic logic [63:0] lk_res(input logic [31:0] ins);
        logic [63:0] r = '0;
        for (int i = 0; i < rm_n; i++) if (rm_instr[i] == ins) r = rm_res[i];
        return r;
    endfunction

    function automatic logic [63:0] lk_pc(input logic [31:0] ins);
        logic [63:0] r = '0;
        for (int i = 0; i < rm_n; i++) if (rm_instr[i] == ins) r = rm_pc[i];
        return r;
    endfunction

    // Processor stand-in: answers for whatever instruction is on the bus.
    always @(negedge clk) begin
        result_i = lk_res(instruction);
        pc_i     = lk_pc(instruction);
    end

    task automatic set_resp(input logic [31:0] ins, input logic [63:0] res, input logic [63:0] pc);
        for (int i = 0; i < rm_n; i++) begin
            if (rm_instr[i] == ins) begin
                rm_res[i] = res;
                rm_pc[i]  = pc;
                return;
            end
        end
        if (rm_n < RM_MAX) begin
            rm_instr[rm_n] = ins;
            rm_res[rm_n]   = res;
            rm_pc[rm_n]    = pc;
            rm_n++;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic entry_t mk(input logic [31:0] ins, input kind_e k, input logic [63:0] ev);
        entry_t e;
        e.instr   = ins;
        e.kind    = k;
        e.exp_val = ev;
        return e;
    endfunction

    task automatic prog(input int addr, input entry_t e);
        prog_we     = 1'b1;
        prog_addr   = AW'(addr);
        prog_instr  = e.instr;
        prog_kind   = e.kind;
        prog_expect = e.exp_val;
        tbl[addr]   = e;
        tick();
        prog_we = 1'b0;
    endtask

    // Reference: tally each entry's check against the responder's answer.
    task automatic model(input int n, output int p, output int f, output int ffi);
        logic [63:0] got;
        p = 0; f = 0; ffi = -1;
        for (int i = 0; i < n; i++) begin
            if (tbl[i].kind == KIND_RESULT)  got = lk_res(tbl[i].instr);
            else if (tbl[i].kind == KIND_PC) got = lk_pc(tbl[i].instr);
            else continue;
            if (got == tbl[i].exp_val) p++;
            else begin
                f++;
                if (ffi < 0) ffi = i;
            end
        end
    endtask

    task automatic start_run(input int n);
        num_entries = CW'(n);
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the start edge; walks every slot and checks the totals.
    task automatic follow(input int n_req, input string tag);
        int eff, p, f, ffi;
        eff = (n_req > DEPTH) ? DEPTH : n_req;
        model(eff, p, f, ffi);
        if (eff == 0) begin
            chk({tag, "_busy"}, 64'(busy), 64'd0);
        end else begin
            for (int k = 0; k < eff; k++) begin
                chk({tag, "_instr"}, 64'(instruction), 64'(tbl[k].instr));
                chk({tag, "_busy"}, 64'(busy), 64'd1);
                repeat (HOLD) tick();
            end
            chk({tag, "_nop"}, 64'(instruction), 64'(NOP));
            chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_pass"}, 64'(pass_cnt), 64'(p));
        chk({tag, "_fail"}, 64'(fail_cnt), 64'(f));
        chk({tag, "_anyf"}, 64'(any_fail), (f > 0) ? 64'd1 : 64'd0);
        chk({tag, "_ffi"}, 64'(first_fail_idx), (ffi < 0) ? 64'((1 << AW) - 1) : 64'(ffi));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_instr"}, 64'(instruction), 64'(NOP));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass_cnt), 64'd0);
        chk({tag, "_fail"}, 64'(fail_cnt), 64'd0);
        chk({tag, "_ffi"}, 64'(first_fail_idx), 64'((1 << AW) - 1));
        chk({tag, "_anyf"}, 64'(any_fail), 64'd0);
    endtask

    task automatic prog_basic();
        prog(0, mk(32'h00A00093, KIND_RESULT, 64'hA));
        prog(1, mk(32'h01408113, KIND_RESULT, 64'h1E));
        prog(2, mk(32'h002081B3, KIND_RESULT, 64'h28));
    endtask

    task automatic add_vec(input logic [31:0] ins, input kind_e k, input logic [63:0] ev,
                           input logic [63:0] res, input logic [63:0] pc, input int p, input int f);
        vec_t v;
        v.e = mk(ins, k, ev); v.res = res; v.pc = pc; v.exp_p = p; v.exp_f = f;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, f, ffi;
        reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_instr = '0; prog_kind = '0;
        prog_expect = '0; num_entries = '0; start = 1'b0; abort = 1'b0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic three-entry program, all matching.
        set_resp(32'h00A00093, 64'hA, 64'h0);
        set_resp(32'h01408113, 64'h1E, 64'h0);
        set_resp(32'h002081B3, 64'h28, 64'h0);
        prog_basic();
        start_run(3);
        follow(3, "basic");
        chk("basic_pass_c", 64'(pass_cnt), 64'd3);
        chk("basic_fail_c", 64'(fail_cnt), 64'd0);

        // Entry 1 now expects the wrong value.
        prog(1, mk(32'h01408113, KIND_RESULT, 64'h1F));
        start_run(3);
        follow(3, "fail1");
        chk("fail1_pass_c", 64'(pass_cnt), 64'd2);
        chk("fail1_fail_c", 64'(fail_cnt), 64'd1);
        chk("fail1_ffi_c", 64'(first_fail_idx), 64'd1);

        // Single-entry vectors: pc checks, no-check kinds, full-width compare.
        add_vec(32'h06310263, KIND_PC,     64'h7A, 64'h0, 64'h7A, 1, 0);
        add_vec(32'h06310263, KIND_PC,     64'h7A, 64'h0, 64'h7C, 0, 1);
        add_vec(32'h00100013, KIND_NONE,   64'h5,  64'h5, 64'h0,  0, 0);
        add_vec(32'h00200013, KIND_RSVD,   64'h5,  64'h5, 64'h0,  0, 0);
        add_vec(32'h00300093, KIND_RESULT, 64'h8000_0000_0000_0001, 64'h1, 64'h0, 0, 1);
        add_vec(32'h00400093, KIND_RESULT, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0);
        add_vec(32'h00500093, KIND_PC,     64'h100, 64'h100, 64'h104, 0, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            set_resp(vecs[i].e.instr, vecs[i].res, vecs[i].pc);
            prog(0, vecs[i].e);
            start_run(1);
            follow(1, "vec");
            chk("vec_pass_c", 64'(pass_cnt), 64'(vecs[i].exp_p));
            chk("vec_fail_c", 64'(fail_cnt), 64'(vecs[i].exp_f));
        end

        // Zero entries: done at once, busy never raised.
        start_run(0);
        follow(0, "zero");

        // Random tables, including an over-long request clamped to DEPTH.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] ins;
                logic [63:0] ev, res, pc;
                kind_e       k;
                ins = {1'b1, 25'($urandom), 6'(i)};
                k   = kind_e'(2'($urandom_range(0, 3)));
                ev  = {$urandom, $urandom};
                res = ($urandom_range(0, 1) == 1) ? ev : {$urandom, $urandom};
                pc  = ($urandom_range(0, 1) == 1) ? ev : {$urandom, $urandom};
                set_resp(ins, res, pc);
                prog(i, mk(ins, k, ev));
            end
            if (r == 2) begin
                start_run(DEPTH + 5);
                follow(DEPTH + 5, "rand_clamp");
            end else begin
                p = $urandom_range(1, DEPTH);
                start_run(p);
                follow(p, "rand");
            end
        end

        // Abort while entry 2 is on the bus.
        prog_basic();
        start_run(3);
        repeat (4) tick();
        chk("abort_pre_instr", 64'(instruction), 64'(tbl[2].instr));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_instr", 64'(instruction), 64'(NOP));
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        model(2, p, f, ffi);
        chk("abort_pass", 64'(pass_cnt), 64'(p));
        chk("abort_fail", 64'(fail_cnt), 64'(f));
        repeat (3) tick();
        chk("abort_frozen", 64'(pass_cnt), 64'(p));
        abort = 1'b1; start = 1'b1; num_entries = CW'(3);
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_prio_busy", 64'(busy), 64'd0);
        chk("abort_prio_instr", 64'(instruction), 64'(NOP));
        start_run(3);
        chk("restart_clr", 64'(pass_cnt), 64'd0);
        follow(3, "restart");

        // Asynchronous reset between edges mid-run; table must survive.
        start_run(3);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        start_run(3);
        follow(3, "postrst");

        // prog_we and start during a run are both ignored.
        start_run(3);
        tick();
        prog_we = 1'b1; prog_addr = AW'(1); prog_instr = 32'hDEAD0093;
        prog_kind = KIND_RESULT; prog_expect = 64'h99;
        start = 1'b1; num_entries = CW'(1);
        tick();
        prog_we = 1'b0; start = 1'b0;
        chk("busy_wr_busy", 64'(busy), 64'd1);
        chk("busy_wr_instr1", 64'(instruction), 64'(tbl[1].instr));
        repeat (2) tick();
        chk("busy_wr_instr2", 64'(instruction), 64'(tbl[2].instr));
        repeat (2) tick();
        chk("busy_wr_done", 64'(done), 64'd1);
        model(3, p, f, ffi);
        chk("busy_wr_pass", 64'(pass_cnt), 64'(p));
        start_run(3);
        follow(3, "busy_wr_tbl");

        // Write and start in the same cycle: the run picks up the new entry 0.
        set_resp(32'h00600093, 64'h6, 64'h0);
        prog_we = 1'b1; prog_addr = '0; prog_instr = 32'h00600093;
        prog_kind = KIND_RESULT; prog_expect = 64'h6;
        tbl[0] = mk(32'h00600093, KIND_RESULT, 64'h6);
        num_entries = CW'(1); start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        follow(1, "wr_start");
        chk("wr_start_pass", 64'(pass_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
